// File: rtl/servo_pose_sequencer.sv
// servo_pose_sequencer
//   N-channel gesture-to-servo driver. A gesture code selects one row of a
//   runtime-writable pose table. That row becomes the target width for every
//   channel. Each channel's applied width slews toward its target by at most
//   STEP_US per PWM frame, and only on frame boundaries. A pulse that has
//   already started is never reshaped.
//
// Ports
//   clk, reset     system clock; asynchronous active-low reset (released synchronously)
//   gesture        gesture code, 0 = hold; qualified by gesture_valid (one cycle)
//   cfg_we         pose table write strobe for table[cfg_pose][cfg_ch] <= clamp(cfg_width)
//   pwm_out        registered servo PWM, one bit per channel
//   cur_width      applied widths in us, channel 0 in [15:0]
//   frame_start    one-cycle pulse when the microsecond frame counter wraps to 0
//   busy           any channel still moving toward its target
//   gesture_err    one-cycle pulse for a gesture code above NUM_POSES
module servo_pose_sequencer #(
    parameter int NUM_CH     = 5,
    parameter int NUM_POSES  = 16,
    parameter int GW         = 8,
    parameter int CLK_HZ     = 50_000_000,
    parameter int PERIOD_US  = 20000,
    parameter int MIN_US     = 1000,
    parameter int MAX_US     = 2000,
    parameter int DEFAULT_US = 1500,
    parameter int STEP_US    = 50,
    localparam int PW        = (NUM_POSES > 1) ? $clog2(NUM_POSES) : 1,
    localparam int CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [GW-1:0]        gesture,
    input  logic                 gesture_valid,
    input  logic                 cfg_we,
    input  logic [PW-1:0]        cfg_pose,
    input  logic [CW-1:0]        cfg_ch,
    input  logic [15:0]          cfg_width,
    output logic [NUM_CH-1:0]    pwm_out,
    output logic [NUM_CH*16-1:0] cur_width,
    output logic                 frame_start,
    output logic                 busy,
    output logic                 gesture_err
);

    localparam int DIV = CLK_HZ / 1_000_000;
    localparam int PSW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FW  = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;

    typedef enum logic [1:0] {HOLD = 2'd0, RISE = 2'd1, FALL = 2'd2} slew_e;

    logic [1:0]        rst_sync_q;
    logic              rst_n;
    logic              us_tick;
    logic [PSW-1:0]    presc_q, presc_d;
    logic [FW-1:0]     frame_us_q, frame_us_d;
    logic              frame_start_q, frame_start_d;
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic              gesture_err_q, gesture_err_d;
    logic [15:0]       cur_q    [NUM_CH];
    logic [15:0]       cur_d    [NUM_CH];
    logic [15:0]       target_q [NUM_CH];
    logic [15:0]       target_d [NUM_CH];
    logic [15:0]       table_q  [NUM_POSES][NUM_CH];
    logic [15:0]       table_d  [NUM_POSES][NUM_CH];
    slew_e             state_q  [NUM_CH];
    slew_e             state_d  [NUM_CH];

    function automatic logic [15:0] clamp_width(input logic [15:0] w);
        logic [15:0] r;
        r = w;
        if (w < 16'(MIN_US)) r = 16'(MIN_US);
        else if (w > 16'(MAX_US)) r = 16'(MAX_US);
        return r;
    endfunction

    // 17-bit intermediates so cur +/- STEP_US can never wrap before the
    // comparison against the target.
    function automatic logic [15:0] slew_step(input slew_e st, input logic [15:0] cur,
                                              input logic [15:0] tgt);
        logic [16:0] up;
        logic [16:0] lim;
        logic [15:0] r;
        up  = {1'b0, cur} + 17'(STEP_US);
        lim = {1'b0, tgt} + 17'(STEP_US);
        r   = cur;
        if (STEP_US == 0) begin
            r = tgt;
        end else begin
            case (st)
                RISE:    r = (up >= {1'b0, tgt}) ? tgt : up[15:0];
                FALL:    r = ({1'b0, cur} <= lim) ? tgt : (cur - 16'(STEP_US));
                default: r = cur;
            endcase
        end
        return r;
    endfunction

    // Reset asserts asynchronously, so PWM drops at once, and releases on a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    always_comb begin
        us_tick       = (presc_q == PSW'(DIV - 1));
        presc_d       = us_tick ? '0 : presc_q + PSW'(1);
        frame_us_d    = frame_us_q;
        frame_start_d = 1'b0;
        if (us_tick) begin
            if (frame_us_q == FW'(PERIOD_US - 1)) begin
                frame_us_d    = '0;
                frame_start_d = 1'b1;
            end else begin
                frame_us_d = frame_us_q + FW'(1);
            end
        end

        // A gesture reads table_q, the value before this cycle's write.
        // That gives read-before-write when both hit the same entry.
        gesture_err_d = gesture_valid && (32'(gesture) > NUM_POSES);
        for (int i = 0; i < NUM_CH; i++) target_d[i] = target_q[i];
        if (gesture_valid) begin
            for (int p = 0; p < NUM_POSES; p++) begin
                if (32'(gesture) == p + 1) begin
                    for (int i = 0; i < NUM_CH; i++) target_d[i] = table_q[p][i];
                end
            end
        end

        for (int p = 0; p < NUM_POSES; p++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                table_d[p][c] = table_q[p][c];
                if (cfg_we && (32'(cfg_pose) == p) && (32'(cfg_ch) == c))
                    table_d[p][c] = clamp_width(cfg_width);
            end
        end

        // Widths move only on frame_start. The direction is re-derived from
        // the post-step width and the post-load target.
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_d[i] = (32'(frame_us_q) < 32'(cur_q[i]));
            cur_d[i] = frame_start_q ? slew_step(state_q[i], cur_q[i], target_q[i]) : cur_q[i];
            if (cur_d[i] < target_d[i])      state_d[i] = RISE;
            else if (cur_d[i] > target_d[i]) state_d[i] = FALL;
            else                             state_d[i] = HOLD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q       <= '0;
            frame_us_q    <= '0;
            frame_start_q <= 1'b0;
            pwm_q         <= '0;
            gesture_err_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                cur_q[i]    <= 16'(DEFAULT_US);
                target_q[i] <= 16'(DEFAULT_US);
                state_q[i]  <= HOLD;
            end
            for (int p = 0; p < NUM_POSES; p++)
                for (int c = 0; c < NUM_CH; c++)
                    table_q[p][c] <= 16'(DEFAULT_US);
        end else begin
            presc_q       <= presc_d;
            frame_us_q    <= frame_us_d;
            frame_start_q <= frame_start_d;
            pwm_q         <= pwm_d;
            gesture_err_q <= gesture_err_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cur_q[i]    <= cur_d[i];
                target_q[i] <= target_d[i];
                state_q[i]  <= state_d[i];
            end
            for (int p = 0; p < NUM_POSES; p++)
                for (int c = 0; c < NUM_CH; c++)
                    table_q[p][c] <= table_d[p][c];
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NUM_CH; i++)
            if (state_q[i] != HOLD) busy = 1'b1;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cur
        assign cur_width[16*g +: 16] = cur_q[g];
    end

    assign pwm_out     = pwm_q;
    assign frame_start = frame_start_q;
    assign gesture_err = gesture_err_q;

endmodule

// File: tb/tb_servo_pose_sequencer.sv
`timescale 1ns/1ps
module tb_servo_pose_sequencer;

    localparam int NC   = 5;
    localparam int NP   = 16;
    localparam int GW   = 8;
    localparam int P    = 2000;
    localparam int STEP = 50;
    localparam int DEF  = 1500;
    localparam int MINW = 1000;
    localparam int MAXW = 2000;
    localparam int PW   = 4;
    localparam int CW   = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [GW-1:0]   gesture = '0;
    logic            gesture_valid = 1'b0;
    logic            cfg_we = 1'b0;
    logic [PW-1:0]   cfg_pose = '0;
    logic [CW-1:0]   cfg_ch = '0;
    logic [15:0]     cfg_width = '0;
    logic [NC-1:0]   pwm_out, pwm0;
    logic [NC*16-1:0] cur_width, cw0;
    logic            frame_start, fs0, busy, busy0, gesture_err, err0;

    always #5 clk = ~clk;

    servo_pose_sequencer #(.NUM_CH(NC), .NUM_POSES(NP), .GW(GW), .CLK_HZ(1_000_000),
        .PERIOD_US(P), .MIN_US(MINW), .MAX_US(MAXW), .DEFAULT_US(DEF), .STEP_US(STEP)) dut (
        .clk(clk), .reset(reset), .gesture(gesture), .gesture_valid(gesture_valid),
        .cfg_we(cfg_we), .cfg_pose(cfg_pose), .cfg_ch(cfg_ch), .cfg_width(cfg_width),
        .pwm_out(pwm_out), .cur_width(cur_width), .frame_start(frame_start),
        .busy(busy), .gesture_err(gesture_err));

    servo_pose_sequencer #(.NUM_CH(NC), .NUM_POSES(NP), .GW(GW), .CLK_HZ(1_000_000),
        .PERIOD_US(P), .MIN_US(MINW), .MAX_US(MAXW), .DEFAULT_US(DEF), .STEP_US(0)) dut0 (
        .clk(clk), .reset(reset), .gesture(gesture), .gesture_valid(gesture_valid),
        .cfg_we(cfg_we), .cfg_pose(cfg_pose), .cfg_ch(cfg_ch), .cfg_width(cfg_width),
        .pwm_out(pwm0), .cur_width(cw0), .frame_start(fs0),
        .busy(busy0), .gesture_err(err0));

    int n_cmp = 0;
    int n_mis = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: whole-frame view of the sequencer in plain integers.
    int m_tab [NP][NC];
    int m_tgt [NC];
    int m_cur [NC];
    int m_cur0 [NC];
    int cyc, rel;
    logic [NC-1:0] e_pwm;
    bit e_fs, e_err;

    function automatic int toward(int c, int t, int s);
        if (s == 0) return t;
        if (c < t) return (c + s < t) ? c + s : t;
        if (c > t) return (c - s > t) ? c - s : t;
        return c;
    endfunction

    function automatic int clampw(int w);
        if (w < MINW) return MINW;
        if (w > MAXW) return MAXW;
        return w;
    endfunction

    task automatic model_edge();
        int pos, g;
        if (!reset) begin
            for (int p = 0; p < NP; p++)
                for (int c = 0; c < NC; c++) m_tab[p][c] = DEF;
            for (int i = 0; i < NC; i++) begin
                m_tgt[i] = DEF; m_cur[i] = DEF; m_cur0[i] = DEF;
            end
            cyc = 0; rel = 0; e_pwm = '0; e_fs = 0; e_err = 0;
            return;
        end
        if (rel < 2) begin
            rel++;
            return;
        end
        pos = cyc % P;
        for (int i = 0; i < NC; i++) e_pwm[i] = (pos < m_cur[i]);
        if (e_fs) begin
            for (int i = 0; i < NC; i++) begin
                m_cur[i]  = toward(m_cur[i], m_tgt[i], STEP);
                m_cur0[i] = toward(m_cur0[i], m_tgt[i], 0);
            end
        end
        e_err = 0;
        if (gesture_valid) begin
            g = int'(gesture);
            if (g >= 1 && g <= NP) begin
                for (int i = 0; i < NC; i++) m_tgt[i] = m_tab[g-1][i];
            end else if (g > NP) begin
                e_err = 1;
            end
        end
        if (cfg_we && int'(cfg_pose) < NP && int'(cfg_ch) < NC)
            m_tab[cfg_pose][cfg_ch] = clampw(int'(cfg_width));
        cyc++;
        e_fs = (cyc % P == 0);
    endtask

    always @(posedge clk or negedge reset) model_edge();

    task automatic cycle_check();
        logic [NC*16-1:0] ew, ew0;
        logic eb, eb0;
        eb = 0; eb0 = 0;
        for (int i = 0; i < NC; i++) begin
            ew[16*i +: 16]  = 16'(m_cur[i]);
            ew0[16*i +: 16] = 16'(m_cur0[i]);
            if (m_cur[i] != m_tgt[i])  eb = 1;
            if (m_cur0[i] != m_tgt[i]) eb0 = 1;
        end
        chk("pwm", pwm_out, e_pwm);
        chk("cur_width", cur_width, ew);
        chk("busy", busy, eb);
        chk("frame_start", frame_start, e_fs);
        chk("gesture_err", gesture_err, e_err);
        chk("cur_width_step0", cw0, ew0);
        chk("busy_step0", busy0, eb0);
        if (n_mis > 40) begin
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
            $finish;
        end
    endtask

    always @(negedge clk) if (chk_on) cycle_check();

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int pose, input int ch, input int w);
        cfg_we = 1; cfg_pose = PW'(pose); cfg_ch = CW'(ch); cfg_width = 16'(w);
        tick();
        cfg_we = 0;
    endtask

    task automatic send_gesture(input int g);
        gesture = GW'(g); gesture_valid = 1;
        tick();
        gesture_valid = 0; gesture = '0;
    endtask

    task automatic wait_frames(input int n);
        for (int k = 0; k < n; k++) begin
            int cnt;
            cnt = 0;
            do begin
                tick();
                cnt++;
            end while (frame_start !== 1'b1 && cnt < P + 10);
            if (frame_start !== 1'b1) chk("frame_timeout", frame_start, 1);
        end
    endtask

    function automatic logic [NC*16-1:0] all_width(input int v);
        logic [NC*16-1:0] r;
        for (int i = 0; i < NC; i++) r[16*i +: 16] = 16'(v);
        return r;
    endfunction

    initial begin
        int hi, fsn;
        // Reset state
        repeat (3) tick();
        chk_on = 1;
        chk("rst_pwm", pwm_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_err", gesture_err, 0);
        chk("rst_width", cur_width, all_width(DEF));
        @(posedge clk); #3 reset = 1;

        // Idle frame: 1500 high / 500 low, one frame_start per frame
        wait_frames(1);
        hi = 0; fsn = 0;
        for (int k = 0; k < P; k++) begin
            tick();
            if (pwm_out[0]) hi++;
            if (frame_start) fsn++;
        end
        chk("idle_high_clks", hi, 1500);
        chk("idle_fs_count", fsn, 1);
        chk("idle_busy", busy, 0);

        // Ramp ch1 1500 -> 1000 over 10 frames
        cfg_write(2, 1, 1000);
        send_gesture(3);
        chk("t2_busy_start", busy, 1);
        wait_frames(1); tick();
        chk("t2_ch1_first", cur_width[31:16], 1450);
        chk("t2_step0_ch1", cw0[31:16], 1000);
        wait_frames(9);
        chk("t2_ch1_before_last", cur_width[31:16], 1050);
        chk("t2_busy_before_last", busy, 1);
        tick();
        chk("t2_ch1_final", cur_width[31:16], 1000);
        chk("t2_busy_end", busy, 0);
        chk("t2_ch0_still", cur_width[15:0], 1500);

        // Clamping on write
        cfg_write(0, 0, 2500);
        send_gesture(1);
        wait_frames(1); tick();
        chk("t3_clamp_high", cw0[15:0], 2000);
        chk("t3_ch0_step", cur_width[15:0], 1550);
        cfg_write(0, 0, 200);
        send_gesture(1);
        wait_frames(1); tick();
        chk("t3_clamp_low", cw0[15:0], 1000);
        chk("t3_ch0_back", cur_width[15:0], 1500);

        // Hold code and out-of-range code
        send_gesture(0);
        chk("t4_err_hold", gesture_err, 0);
        send_gesture(17);
        chk("t4_err_pulse", gesture_err, 1);
        tick();
        chk("t4_err_clear", gesture_err, 0);
        wait_frames(1); tick();
        chk("t4_target_kept", cw0[15:0], 1000);

        // Reversal mid-move
        cfg_write(4, 2, 1000);
        cfg_write(5, 2, 2000);
        send_gesture(5);
        wait_frames(3); tick();
        chk("t5_ch2_down", cur_width[47:32], 1350);
        send_gesture(6);
        wait_frames(1); tick();
        chk("t5_ch2_reverse", cur_width[47:32], 1400);
        chk("t5_step0_jump", cw0[47:32], 2000);

        // Randomized traffic
        for (int k = 0; k < 4 * P; k++) begin
            gesture_valid = ($urandom_range(0, 59) == 0);
            gesture       = GW'($urandom_range(0, 20));
            cfg_we        = ($urandom_range(0, 19) == 0);
            cfg_pose      = PW'($urandom_range(0, 15));
            cfg_ch        = CW'($urandom_range(0, 7));
            cfg_width     = 16'($urandom_range(0, 3000));
            tick();
        end
        gesture_valid = 0; cfg_we = 0; gesture = '0;

        // Reset mid-frame during a move
        cfg_write(9, 3, 2000);
        cfg_write(9, 4, 1000);
        send_gesture(10);
        wait_frames(1);
        repeat (5) tick();
        chk("t6_pwm_pre", pwm_out, {NC{1'b1}});
        @(posedge clk); #3 reset = 0;
        #1;
        chk("t6_pwm_now", pwm_out, 0);
        chk("t6_busy_rst", busy, 0);
        chk("t6_width_rst", cur_width, all_width(DEF));
        chk("t6_fs_rst", frame_start, 0);
        repeat (3) tick();
        @(posedge clk); #3 reset = 1;
        repeat (3) tick();
        send_gesture(3);
        chk("t6_table_reset", busy, 0);

        // Same-cycle write and gesture on one entry loads the old value
        cfg_we = 1; cfg_pose = PW'(7); cfg_ch = CW'(0); cfg_width = 16'(1000);
        gesture = GW'(8); gesture_valid = 1;
        tick();
        cfg_we = 0; gesture_valid = 0; gesture = '0;
        chk("t6_rbw_busy", busy, 0);
        send_gesture(8);
        chk("t6_new_busy", busy, 1);
        wait_frames(1); tick();
        chk("t6_new_step0", cw0[15:0], 1000);
        chk("t6_new_step", cur_width[15:0], 1450);

        chk_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
